dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, gives RAM depth of 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter TX_DEPTH, default 4, gives TX byte FIFO depth; legal values are 2-7.
REQ-003 clock  input  1  master clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (reset=0 resets state at the next rising edge).
REQ-005 address_dmem  input  32  word address from the processor memory stage.
REQ-006 data  input  32  write data from the processor.
REQ-007 wren  input  1  write enable; 1 = write, 0 = read.
REQ-008 q_dmem  output  32  registered read data returned to the processor.
REQ-009 tx_data  output  8  head byte of the TX FIFO.
REQ-010 tx_valid  output  1  TX FIFO non-empty.
REQ-011 tx_ready  input  1  the sink accepts tx_data when tx_valid=1 and tx_ready=1.

Function
REQ-012 MMIO decode: address_dmem[31:16]==0 and address_dmem[15:4]==12'hFFF; all other addresses access RAM at index address_dmem[DEPTH_LOG2-1:0], with upper bits ignored (aliasing).
REQ-013 RAM write: when wren=1, the RAM word is written at the edge.
REQ-014 RAM read latency is one cycle: q_dmem at edge k holds the word addressed before edge k.
REQ-015 Same-cycle RAM read and write to one address is read-first: q_dmem returns the old word.
REQ-016 q_dmem updates every cycle regardless of wren; during a write, q_dmem shows the pre-write word at that address.
REQ-017 0xFFF0 write pushes data[7:0] into the TX FIFO if it is not full.
REQ-018 0xFFF0 write while full drops the byte and sets the sticky flag ovf.
REQ-019 0xFFF0 read returns 0.
REQ-020 0xFFF1 read returns {27'b0, ovf, full, count[2:0]}, where count = FIFO occupancy (0..TX_DEPTH) and full = (count==TX_DEPTH).
REQ-021 0xFFF1 write (any data) clears ovf.
REQ-022 0xFFF2 read returns cyc, a 32-bit free-running counter sampled before the edge.
REQ-023 cyc increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
REQ-024 0xFFF2 write loads cyc=data; the load overrides that cycle's increment.
REQ-025 Other MMIO addresses (0xFFF3-0xFFFF): reads return 0, writes are ignored.
REQ-026 MMIO accesses never touch the RAM.
REQ-027 TX FIFO is first-in first-out; tx_data = head entry; a pop occurs at the edge when tx_valid and tx_ready are both 1.
REQ-028 tx_valid and tx_data are registered state only (no combinational path from the address_dmem, data or wren inputs).
REQ-029 Simultaneous push and pop when full: both succeed, count stays at TX_DEPTH, ovf unchanged.
REQ-030 Push when empty: count becomes 1 and tx_valid rises in the next cycle; no same-cycle bypass.
REQ-031 Status reads sample occupancy before the same edge's push/pop.
REQ-032 FIFO pointers wrap modulo TX_DEPTH.

Reset
REQ-033 At an edge with reset=0: q_dmem=0, FIFO emptied (count=0, tx_valid=0), ovf=0, cyc=0.
REQ-034 At an edge with reset=0, tx_data is undefined, but tx_valid=0.
REQ-035 RAM contents are not reset.
REQ-036 Reset overrides any same-cycle write, push, pop or load.
REQ-037 The cycle after reset deasserts, cyc=1.

Verification
REQ-038 Write 0x12345678 to addr 5, then read addr 5 -> q_dmem=0x12345678 one cycle after the read; read addr 0x405 (DEPTH_LOG2=10) -> same value (alias).
REQ-039 Addr 5 holds 0xA; in one cycle write 0xB to addr 5 with wren=1 -> q_dmem=0xA; next read -> 0xB.
REQ-040 tx_ready=0, push 0x41..0x45 (5 writes to 0xFFF0) -> status=0x1C; then tx_ready=1 -> bytes 0x41,0x42,0x43,0x44 drain in order, status=0x10; write 0xFFF1 -> status=0x00.
REQ-041 FIFO full, tx_ready=1, push 0x55 in the same cycle -> count stays 4, ovf=0, 0x55 emerges fourth.
REQ-042 3 bytes queued, reset=0 for one cycle -> tx_valid=0 next cycle and status=0.
REQ-043 Write 0xFFFFFFFE to 0xFFF2, then back-to-back reads of 0xFFF2 -> q_dmem sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a small MMIO block with a TX byte FIFO,
// FIFO status/overflow register and a free-running cycle counter.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int TX_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int         RAM_WORDS = 1 << DEPTH_LOG2;
    localparam logic [2:0] CNT_FULL  = 3'(TX_DEPTH);
    localparam logic [2:0] PTR_LAST  = 3'(TX_DEPTH - 1);

    typedef enum logic [3:0] {
        REG_TX_DATA   = 4'h0,
        REG_TX_STATUS = 4'h1,
        REG_CYCLE     = 4'h2
    } mmio_reg_e;

    logic [31:0] ram [RAM_WORDS];
    // Sized to the 3-bit pointer range; only the first TX_DEPTH entries are used.
    logic [7:0]  fifo_mem [8];

    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] q_dmem_q, q_dmem_d;

    logic                  is_mmio, ram_we, full, pop, push_req, push;
    logic                  ovf_clr, cyc_load;
    logic [DEPTH_LOG2-1:0] ram_idx;
    mmio_reg_e             reg_sel;
    logic [31:0]           mmio_rdata;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        is_mmio  = (address_dmem[31:16] == 16'h0000) && (address_dmem[15:4] == 12'hFFF);
        reg_sel  = mmio_reg_e'(address_dmem[3:0]);
        ram_idx  = address_dmem[DEPTH_LOG2-1:0];
        ram_we   = wren && !is_mmio && reset;
        full     = (count_q == CNT_FULL);
        pop      = (count_q != 3'd0) && tx_ready;
        push_req = wren && is_mmio && (reg_sel == REG_TX_DATA);
        // A push into a full FIFO still lands when the head leaves on the same edge.
        push     = push_req && (!full || pop);
        ovf_clr  = wren && is_mmio && (reg_sel == REG_TX_STATUS);
        cyc_load = wren && is_mmio && (reg_sel == REG_CYCLE);

        case (reg_sel)
            REG_TX_STATUS: mmio_rdata = {27'b0, ovf_q, full, count_q};
            REG_CYCLE:     mmio_rdata = cyc_q;
            default:       mmio_rdata = 32'h0;
        endcase

        q_dmem_d = is_mmio ? mmio_rdata : ram[ram_idx];

        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? 3'd0 : wr_ptr_q + 3'd1;
        rd_ptr_d = rd_ptr_q;
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? 3'd0 : rd_ptr_q + 3'd1;
        count_d  = count_q + {2'b0, push} - {2'b0, pop};

        ovf_d = ovf_q;
        if (ovf_clr)             ovf_d = 1'b0;
        else if (push_req && !push) ovf_d = 1'b1;

        cyc_d = cyc_load ? data : cyc_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            q_dmem_q <= 32'h0;
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            cyc_q    <= 32'h0;
        end else begin
            q_dmem_q <= q_dmem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cyc_q    <= cyc_d;
        end
    end

    // NOTE: storage arrays carry no reset so they map onto RAM/LUT-RAM; only valid-tracking state is reset.
    always_ff @(posedge clock) begin
        if (ram_we) ram[ram_idx] <= data;
        if (push && reset) fifo_mem[wr_ptr_q] <= data[7:0];
    end

    assign q_dmem   = q_dmem_q;
    assign tx_data  = fifo_mem[rd_ptr_q];
    assign tx_valid = (count_q != 3'd0);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: per-cycle expectations and expected TX bytes
// are queued by the driver and compared by two independent monitor processes.
module tb_dmem_responder;

    logic        clock        = 1'b0;
    logic        reset        = 1'b0;
    logic [31:0] address_dmem = 32'h0;
    logic [31:0] data         = 32'h0;
    logic        wren         = 1'b0;
    logic        tx_ready     = 1'b0;
    logic [31:0] q_dmem;
    logic [7:0]  tx_data;
    logic        tx_valid;

    dmem_responder #(.DEPTH_LOG2(10), .TX_DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        chk_q;
        logic [31:0] exp_q;
        logic        chk_v;
        logic        exp_v;
    } step_t;

    step_t       step_q[$];
    logic [7:0]  tx_exp[$];
    int          n_vec   = 0;
    int          n_bad   = 0;
    logic        rst_drv = 1'b0;
    logic        rdy_drv = 1'b0;

    localparam logic [31:0] A_TX   = 32'h0000_FFF0;
    localparam logic [31:0] A_STAT = 32'h0000_FFF1;
    localparam logic [31:0] A_CYC  = 32'h0000_FFF2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic cq, input logic [31:0] eq,
                        input logic cv, input logic ev);
        step_t s;
        @(negedge clock);
        reset        = rst_drv;
        tx_ready     = rdy_drv;
        address_dmem = a;
        data         = d;
        wren         = we;
        s.name  = name;
        s.chk_q = cq;
        s.exp_q = eq;
        s.chk_v = cv;
        s.exp_v = ev;
        step_q.push_back(s);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step("wr", a, d, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
        step(name, a, 32'h0, 1'b0, 1'b1, e, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step("idle", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic expect_out);
        if (expect_out) tx_exp.push_back(b);
        wr(A_TX, {24'h0, b});
    endtask

    // Registered outputs after each edge versus the expectation queued for that cycle.
    step_t cur;
    always begin
        @(posedge clock);
        #1;
        if (step_q.size() != 0) begin
            cur = step_q.pop_front();
            if (cur.chk_q) check({cur.name, ".q_dmem"}, q_dmem, cur.exp_q);
            if (cur.chk_v) check({cur.name, ".tx_valid"}, {31'h0, tx_valid}, {31'h0, cur.exp_v});
        end
    end

    // Every byte handed over (valid && ready before the edge) must be the next expected one.
    always begin
        @(negedge clock);
        #1;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_exp.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL tx_pop: got byte %h, expected no byte", tx_data);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_drv = 1'b0;
        rdy_drv = 1'b0;
        step("rst0", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        step("rst1", 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        rst_drv = 1'b1;
        rd("cyc_first", A_CYC, 32'h0);
        rd("cyc_second", A_CYC, 32'h1);

        // RAM write/read, aliasing, read-first
        wr(32'h5, 32'h1234_5678);
        rd("ram_rd5", 32'h5, 32'h1234_5678);
        rd("ram_alias405", 32'h405, 32'h1234_5678);
        rd("ram_alias_hi", 32'h8000_0005, 32'h1234_5678);
        wr(32'h5, 32'hA);
        step("read_first", 32'h5, 32'hB, 1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
        rd("ram_new", 32'h5, 32'hB);
        wr(32'h6, 32'hCAFE_F00D);
        rd("ram_rd6", 32'h6, 32'hCAFE_F00D);
        rd("ram_rd5_kept", 32'h5, 32'hB);
        wr(32'h3F0, 32'h1111_1111);

        // Cycle counter load and wrap
        wr(A_CYC, 32'hFFFF_FFFE);
        rd("cyc_load", A_CYC, 32'hFFFF_FFFE);
        rd("cyc_max", A_CYC, 32'hFFFF_FFFF);
        rd("cyc_wrap", A_CYC, 32'h0000_0000);

        // Fill, overflow, drain with status sampled before each pop, clear ovf
        rdy_drv = 1'b0;
        push_byte(8'h41, 1'b1);
        push_byte(8'h42, 1'b1);
        push_byte(8'h43, 1'b1);
        push_byte(8'h44, 1'b1);
        push_byte(8'h45, 1'b0);
        rd("stat_ovf_full", A_STAT, 32'h1C);
        rd("txdata_rd", A_TX, 32'h0);
        rdy_drv = 1'b1;
        rd("stat_drain4", A_STAT, 32'h1C);
        rd("stat_drain3", A_STAT, 32'h13);
        rd("stat_drain2", A_STAT, 32'h12);
        rd("stat_drain1", A_STAT, 32'h11);
        rd("stat_empty_ovf", A_STAT, 32'h10);
        wr(A_STAT, 32'hFFFF_FFFF);
        rd("stat_clr", A_STAT, 32'h00);

        // Push and pop on the same edge while full
        rdy_drv = 1'b0;
        push_byte(8'h51, 1'b1);
        push_byte(8'h52, 1'b1);
        push_byte(8'h53, 1'b1);
        push_byte(8'h54, 1'b1);
        rdy_drv = 1'b1;
        push_byte(8'h55, 1'b1);
        rdy_drv = 1'b0;
        rd("stat_full_pp", A_STAT, 32'h0C);
        rdy_drv = 1'b1;
        idle();
        idle();
        idle();
        idle();
        rd("stat_pp_empty", A_STAT, 32'h00);

        // Push into empty FIFO: valid appears only after the edge
        tx_exp.push_back(8'h66);
        step("push_empty", A_TX, 32'h66, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        step("pop_single", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Reset with bytes queued; a same-cycle push must be discarded
        rdy_drv = 1'b0;
        push_byte(8'h71, 1'b0);
        push_byte(8'h72, 1'b0);
        push_byte(8'h73, 1'b0);
        rst_drv = 1'b0;
        step("rst_mid", A_TX, 32'h99, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        rst_drv = 1'b1;
        rd("stat_after_rst", A_STAT, 32'h00);
        rd("cyc_after_rst", A_CYC, 32'h1);

        // Unmapped MMIO and RAM isolation from MMIO
        wr(32'h0000_FFF3, 32'hDEAD_BEEF);
        rd("mmio_fff3", 32'h0000_FFF3, 32'h0);
        rd("mmio_ffff", 32'h0000_FFFF, 32'h0);
        rd("ram_3f0", 32'h3F0, 32'h1111_1111);
        rd("ram_1fff0", 32'h0001_FFF0, 32'h1111_1111);

        idle();
        idle();
        @(posedge clock);
        #3;
        check("tx_exp_left", tx_exp.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
